// File: rtl/band_mixer.sv
// band_mixer: latches N signed band samples, accumulates them one band per clock,
// saturates to the output width and hands the result off with valid/ready.
// Optional macro BAND_MIXER_AVG_EN: output the band mean (sum >>> log2(N)) instead of the sum.
module band_mixer #(
    parameter int NUMBER_OF_FILTERS = 8,
    parameter int FILTER_OUT_BITS   = 16
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] band_ins,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [FILTER_OUT_BITS-1:0]                   mix_out
);

    localparam int IDX_BITS = $clog2(NUMBER_OF_FILTERS);
    localparam int ACC_BITS = FILTER_OUT_BITS + IDX_BITS;
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUMBER_OF_FILTERS - 1);

    if (NUMBER_OF_FILTERS < 2) begin : g_chk_min
        $error("band_mixer: NUMBER_OF_FILTERS must be at least 2");
    end

`ifdef BAND_MIXER_AVG_EN
    if ((1 << IDX_BITS) != NUMBER_OF_FILTERS) begin : g_chk_pow2
        $error("band_mixer: averaging needs NUMBER_OF_FILTERS to be a power of two");
    end
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                                       state_r, state_s;
    logic [NUMBER_OF_FILTERS*FILTER_OUT_BITS-1:0] bands_r, bands_s;
    logic signed [ACC_BITS-1:0]                   acc_r, acc_s;
    logic signed [ACC_BITS-1:0]                   band_ext_s, sum_s, final_s;
    logic signed [FILTER_OUT_BITS-1:0]            band_s;
    logic [IDX_BITS-1:0]                          idx_r, idx_s;
    logic                                         in_ready_r, in_ready_s;
    logic                                         out_valid_r, out_valid_s;
    logic [FILTER_OUT_BITS-1:0]                   mix_r, mix_s;

    // Clamp an accumulator-width value into the signed output range.
    function automatic logic [FILTER_OUT_BITS-1:0] saturate(input logic signed [ACC_BITS-1:0] s);
        logic signed [ACC_BITS-1:0] sat_max;
        logic signed [ACC_BITS-1:0] sat_min;
        sat_max = {{(ACC_BITS-FILTER_OUT_BITS+1){1'b0}}, {(FILTER_OUT_BITS-1){1'b1}}};
        sat_min = {{(ACC_BITS-FILTER_OUT_BITS+1){1'b1}}, {(FILTER_OUT_BITS-1){1'b0}}};
        if (s > sat_max) begin
            saturate = {1'b0, {(FILTER_OUT_BITS-1){1'b1}}};
        end else if (s < sat_min) begin
            saturate = {1'b1, {(FILTER_OUT_BITS-1){1'b0}}};
        end else begin
            saturate = s[FILTER_OUT_BITS-1:0];
        end
    endfunction

    // Running sum with the current band sign-extended; final value optionally scaled to the mean.
    always_comb begin
        band_s     = bands_r[int'(idx_r)*FILTER_OUT_BITS +: FILTER_OUT_BITS];
        band_ext_s = {{IDX_BITS{band_s[FILTER_OUT_BITS-1]}}, band_s};
        sum_s      = acc_r + band_ext_s;
`ifdef BAND_MIXER_AVG_EN
        final_s    = sum_s >>> IDX_BITS;
`else
        final_s    = sum_s;
`endif
    end

    // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
    always_comb begin
        state_s     = state_r;
        bands_s     = bands_r;
        acc_s       = acc_r;
        idx_s       = idx_r;
        out_valid_s = out_valid_r;
        mix_s       = mix_r;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    bands_s = band_ins;
                    acc_s   = '0;
                    idx_s   = '0;
                    state_s = ACCUM;
                end else begin
                    state_s = IDLE;
                end
            end
            ACCUM: begin
                acc_s = sum_s;
                if (idx_r == LAST_IDX) begin
                    mix_s       = saturate(final_s);
                    out_valid_s = 1'b1;
                    idx_s       = '0;
                    state_s     = DONE;
                end else begin
                    idx_s = idx_r + IDX_BITS'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_s = 1'b0;
                    state_s     = IDLE;
                end else begin
                    out_valid_s = 1'b1;
                end
            end
            default: begin
                out_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase
        in_ready_s = (state_s == IDLE);
    end

    // State register; in_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
        end
    end

    // Datapath registers: latched bands, accumulator, band index and output sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bands_r <= '0;
            acc_r   <= '0;
            idx_r   <= '0;
            mix_r   <= '0;
        end else begin
            bands_r <= bands_s;
            acc_r   <= acc_s;
            idx_r   <= idx_s;
            mix_r   <= mix_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign mix_out   = mix_r;

endmodule

// File: tb/tb_band_mixer.sv
// Self-checking bench for band_mixer: directed vector table, randomized sets against
// an arithmetic reference model, plus backpressure and mid-accumulation reset sequences.
module tb_band_mixer;

    localparam int N = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [N*W-1:0] band_ins = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   mix_out;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [N*W-1:0] bands;
        logic [W-1:0]   exp_sum;
        logic [W-1:0]   exp_avg;
    } vec_t;

    vec_t vecs [12];

    band_mixer #(.NUMBER_OF_FILTERS(N), .FILTER_OUT_BITS(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .band_ins(band_ins),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mix_out(mix_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N*W-1:0] pack8(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                             input logic [W-1:0] b2, input logic [W-1:0] b3,
                                             input logic [W-1:0] b4, input logic [W-1:0] b5,
                                             input logic [W-1:0] b6, input logic [W-1:0] b7);
        return {b7, b6, b5, b4, b3, b2, b1, b0};
    endfunction

    // Reference: integer sum of signed bands, optional floor-mean, then clamp.
    function automatic logic [W-1:0] model(input logic [N*W-1:0] b);
        int s;
        s = 0;
        for (int k = 0; k < N; k++) s += int'($signed(b[k*W +: W]));
`ifdef BAND_MIXER_AVG_EN
        s = s >>> $clog2(N);
`endif
        if (s > (1 << (W-1)) - 1) return {1'b0, {(W-1){1'b1}}};
        if (s < -(1 << (W-1)))    return {1'b1, {(W-1){1'b0}}};
        return W'(s);
    endfunction

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Waits (bounded) for out_valid; lat counts edges after the accept edge.
    task automatic wait_out(input string name, input bit noisy);
        int lat;
        lat = -1;
        for (int c = 0; c <= 20; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
            if (noisy) begin
                in_valid = 1'($urandom_range(0, 1));
                band_ins = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        in_valid = 1'b0;
        check({name, " latency"}, lat, N);
    endtask

    task automatic run_sample(input logic [N*W-1:0] bands, input string name, output logic [W-1:0] res);
        wait_ready(name);
        in_valid = 1'b1;
        band_ins = bands;
        @(posedge clk);
        #1;
        wait_out(name, 1'b1);
        res = mix_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, " out_valid cleared"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [W-1:0]   res;
        logic [W-1:0]   exp;
        logic [N*W-1:0] a_set;
        logic [N*W-1:0] b_set;
        logic [N*W-1:0] r_set;
        bit             stale;

        vecs[0]  = '{pack8(16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100), 16'h0800, 16'h0100};
        vecs[1]  = '{pack8(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), 16'h7FFF, 16'h7FFF};
        vecs[2]  = '{pack8(16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000), 16'h8000, 16'h8000};
        vecs[3]  = '{pack8(16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h7FFE, 16'h0FFF};
        vecs[4]  = '{pack8(16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18, 16'h03E8, 16'hFC18), 16'h0000, 16'h0000};
        vecs[5]  = '{pack8(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008), 16'h0024, 16'h0004};
        vecs[6]  = '{pack8(16'hFFF7, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'hFFF7, 16'hFFFE};
        vecs[7]  = '{pack8(16'h4000, 16'h3FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h7FFF, 16'h0FFF};
        vecs[8]  = '{pack8(16'h4000, 16'h4000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h7FFF, 16'h1000};
        vecs[9]  = '{pack8(16'hC000, 16'hC000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h8000, 16'hF000};
        vecs[10] = '{pack8(16'hC000, 16'hC000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000), 16'h8000, 16'hEFFF};
        vecs[11] = '{pack8(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000), 16'h8000, 16'hEFFF};

        // Reset state
        #2;
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset mix_out", {16'd0, mix_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("release in_ready", {31'd0, in_ready}, 32'd1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            run_sample(vecs[i].bands, $sformatf("vec%0d", i), res);
`ifdef BAND_MIXER_AVG_EN
            exp = vecs[i].exp_avg;
`else
            exp = vecs[i].exp_sum;
`endif
            check($sformatf("vec%0d mix_out", i), {16'd0, res}, {16'd0, exp});
        end

        // Randomized sets against the model
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                case (i % 3)
                    0:       r_set[k*W +: W] = W'($urandom);
                    1:       r_set[k*W +: W] = 16'h7000 | W'($urandom_range(0, 4095));
                    default: r_set[k*W +: W] = 16'h8000 | W'($urandom_range(0, 4095));
                endcase
            end
            run_sample(r_set, $sformatf("rand%0d", i), res);
            check($sformatf("rand%0d mix_out", i), {16'd0, res}, {16'd0, model(r_set)});
        end

        // Backpressure: hold DONE, offer a new set that must be ignored until the handshake
        a_set = vecs[0].bands;
        b_set = vecs[5].bands;
        wait_ready("bp_a");
        in_valid = 1'b1;
        band_ins = a_set;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out("bp_a", 1'b0);
        check("bp_a mix_out", {16'd0, mix_out}, {16'd0, model(a_set)});
        in_valid = 1'b1;
        band_ins = b_set;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d mix_out", c), {16'd0, mix_out}, {16'd0, model(a_set)});
            check($sformatf("bp hold%0d in_ready", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp hold%0d out_valid", c), {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp release out_valid", {31'd0, out_valid}, 32'd0);
        check("bp release in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_out("bp_b", 1'b0);
        check("bp_b mix_out", {16'd0, mix_out}, {16'd0, model(b_set)});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset mid-accumulation: no output, registers cleared, no stale result later
        wait_ready("rst");
        in_valid = 1'b1;
        band_ins = vecs[1].bands;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst mix_out", {16'd0, mix_out}, 32'd0);
        check("rst in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        check("rst held in_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst release in_ready", {31'd0, in_ready}, 32'd1);
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("rst no stale output", {31'd0, stale}, 32'd0);

        // Normal operation resumes after the abort
        run_sample(vecs[5].bands, "post_rst", res);
        check("post_rst mix_out", {16'd0, res}, {16'd0, model(vecs[5].bands)});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
